// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU types for the memory / write-back stage: memtoreg encoding,
// stage FSM states and the common word / register-index typedefs.
package mem_wb_stage_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  // Write-back source selected by the EX/MEM memtoreg field.
  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_LOAD = 2'b01,
    MTR_NPC  = 2'b10,
    MTR_LUI  = 2'b11
  } memtoreg_t;

  // Memory stage controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_HALTED = 2'b10
  } mem_state_t;

endpackage

// File: rtl/mem_wb_stage_latch.sv
// MEM/WB pipeline register. Each edge it either captures the completing
// instruction or a bubble; the bubble's halt bit is supplied by the stage
// so a halted pipeline keeps reporting halt.
module mem_wb_latch
  import mem_wb_stage_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     load,
  input  logic     bubble_halt,
  input  logic     regwrite_in,
  input  regbits_t wsel_in,
  input  word_t    wdat_in,
  input  logic     halt_in,
  output logic     wb_regwrite,
  output regbits_t wb_wsel,
  output word_t    wb_wdat,
  output logic     wb_halt
);

  logic     regwrite_q, regwrite_d;
  regbits_t wsel_q, wsel_d;
  word_t    wdat_q, wdat_d;
  logic     halt_q, halt_d;

  // Select between the completing instruction and a bubble.
  always_comb begin
    regwrite_d = 1'b0;
    wsel_d     = '0;
    wdat_d     = '0;
    halt_d     = bubble_halt;
    if (load) begin
      regwrite_d = regwrite_in;
      wsel_d     = wsel_in;
      wdat_d     = wdat_in;
      halt_d     = halt_in;
    end
  end

  // MEM/WB register with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      regwrite_q <= 1'b0;
      wsel_q     <= '0;
      wdat_q     <= '0;
      halt_q     <= 1'b0;
    end else begin
      regwrite_q <= regwrite_d;
      wsel_q     <= wsel_d;
      wdat_q     <= wdat_d;
      halt_q     <= halt_d;
    end
  end

  assign wb_regwrite = regwrite_q;
  assign wb_wsel     = wsel_q;
  assign wb_wdat     = wdat_q;
  assign wb_halt     = halt_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage controller plus write-back mux. Forwards EX/MEM memory
// requests to the data cache, stalls the front of the pipe on a miss,
// and feeds the MEM/WB register with either the result or a bubble.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic [1:0]  ex_memtoreg,
  input  logic        ex_regwrite,
  input  logic        ex_dmemREN,
  input  logic        ex_dmemWEN,
  input  logic        ex_halt,
  input  logic [31:0] ex_aluResult,
  input  logic [31:0] ex_rdat2,
  input  logic [31:0] ex_npc,
  input  logic [31:0] ex_upper16,
  input  logic [4:0]  ex_wsel,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        stall,
  output logic        wb_regwrite,
  output logic [4:0]  wb_wsel,
  output logic [31:0] wb_wdat,
  output logic        wb_halt
);

  mem_state_t state_q, state_d;
  logic       req;
  logic       load;
  word_t      wdat_mux;

  // A read and a write together are simply both forwarded.
  assign req       = ex_dmemREN | ex_dmemWEN;
  assign dmemaddr  = ex_aluResult;
  assign dmemstore = ex_rdat2;

  // Controller state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, cache request, stall and MEM/WB load select.
  always_comb begin
    state_d = state_q;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    stall   = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dmemREN = ex_dmemREN;
        dmemWEN = ex_dmemWEN;
        if (req && !dhit) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
        end else begin
          load = 1'b1;
          if (ex_halt) state_d = ST_HALTED;
        end
      end
      ST_WAIT: begin
        dmemREN = ex_dmemREN;
        dmemWEN = ex_dmemWEN;
        stall   = !dhit;
        if (dhit) begin
          load    = 1'b1;
          state_d = ex_halt ? ST_HALTED : ST_IDLE;
        end
      end
      ST_HALTED: begin
        stall = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write-back data source select.
  always_comb begin
    wdat_mux = ex_aluResult;
    case (memtoreg_t'(ex_memtoreg))
      MTR_ALU:  wdat_mux = ex_aluResult;
      MTR_LOAD: wdat_mux = dmemload;
      MTR_NPC:  wdat_mux = ex_npc;
      MTR_LUI:  wdat_mux = ex_upper16;
      default:  wdat_mux = ex_aluResult;
    endcase
  end

  mem_wb_latch u_latch (
    .CLK         (CLK),
    .nRST        (nRST),
    .load        (load),
    .bubble_halt (state_q == ST_HALTED),
    .regwrite_in (ex_regwrite),
    .wsel_in     (ex_wsel),
    .wdat_in     (wdat_mux),
    .halt_in     (ex_halt),
    .wb_regwrite (wb_regwrite),
    .wb_wsel     (wb_wsel),
    .wb_wdat     (wb_wdat),
    .wb_halt     (wb_halt)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, load hit/miss, store miss,
// write-back mux pass-through, back-to-back traffic, halt and reset in WAIT.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  ex_memtoreg;
  logic        ex_regwrite, ex_dmemREN, ex_dmemWEN, ex_halt;
  logic [31:0] ex_aluResult, ex_rdat2, ex_npc, ex_upper16;
  logic [4:0]  ex_wsel;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN, stall;
  logic [31:0] dmemaddr, dmemstore;
  logic        wb_regwrite, wb_halt;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;

  int nvec = 0;
  int nfail = 0;

  mem_wb_stage dut (
    .CLK(CLK), .nRST(nRST),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_dmemREN(ex_dmemREN), .ex_dmemWEN(ex_dmemWEN), .ex_halt(ex_halt),
    .ex_aluResult(ex_aluResult), .ex_rdat2(ex_rdat2), .ex_npc(ex_npc),
    .ex_upper16(ex_upper16), .ex_wsel(ex_wsel),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .stall(stall),
    .wb_regwrite(wb_regwrite), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .wb_halt(wb_halt)
  );

  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    ex_memtoreg = 2'b00; ex_regwrite = 0; ex_dmemREN = 0; ex_dmemWEN = 0;
    ex_halt = 0; ex_aluResult = 0; ex_rdat2 = 0; ex_npc = 0; ex_upper16 = 0;
    ex_wsel = 0; dhit = 0; dmemload = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 0;
    clear_inputs();
    #2;
    nvec++; if (wb_regwrite !== 1'b0) begin nfail++; $display("FAIL reset_regwrite got %b want 0", wb_regwrite); end
    nvec++; if (wb_wsel !== 5'd0) begin nfail++; $display("FAIL reset_wsel got %0d want 0", wb_wsel); end
    nvec++; if (wb_wdat !== 32'd0) begin nfail++; $display("FAIL reset_wdat got %h want 0", wb_wdat); end
    nvec++; if (wb_halt !== 1'b0) begin nfail++; $display("FAIL reset_halt got %b want 0", wb_halt); end
    nvec++; if (stall !== 1'b0) begin nfail++; $display("FAIL reset_stall got %b want 0", stall); end
    tick();
    nRST = 1;
    tick();
  endtask

  task automatic test_load_hit();
    clear_inputs();
    ex_dmemREN = 1; ex_aluResult = 32'h40; dhit = 1; dmemload = 32'hDEADBEEF;
    ex_memtoreg = 2'b01; ex_wsel = 5; ex_regwrite = 1;
    #1;
    nvec++; if (stall !== 1'b0) begin nfail++; $display("FAIL hit_stall got %b want 0", stall); end
    nvec++; if (dmemREN !== 1'b1) begin nfail++; $display("FAIL hit_ren got %b want 1", dmemREN); end
    nvec++; if (dmemaddr !== 32'h40) begin nfail++; $display("FAIL hit_addr got %h want 00000040", dmemaddr); end
    tick();
    nvec++; if (wb_wdat !== 32'hDEADBEEF) begin nfail++; $display("FAIL hit_wdat got %h want deadbeef", wb_wdat); end
    nvec++; if (wb_wsel !== 5'd5) begin nfail++; $display("FAIL hit_wsel got %0d want 5", wb_wsel); end
    nvec++; if (wb_regwrite !== 1'b1) begin nfail++; $display("FAIL hit_regwrite got %b want 1", wb_regwrite); end
    clear_inputs();
  endtask

  task automatic test_load_miss();
    clear_inputs();
    ex_dmemREN = 1; ex_aluResult = 32'h100; dmemload = 32'hCAFEF00D;
    ex_memtoreg = 2'b01; ex_wsel = 9; ex_regwrite = 1;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3);
      #1;
      nvec++; if (stall !== (i < 3)) begin nfail++; $display("FAIL miss_stall[%0d] got %b want %b", i, stall, (i < 3)); end
      nvec++; if (dmemREN !== 1'b1) begin nfail++; $display("FAIL miss_ren[%0d] got %b want 1", i, dmemREN); end
      tick();
      nvec++; if (wb_regwrite !== (i == 3)) begin nfail++; $display("FAIL miss_wb_regwrite[%0d] got %b want %b", i, wb_regwrite, (i == 3)); end
    end
    nvec++; if (wb_wdat !== 32'hCAFEF00D) begin nfail++; $display("FAIL miss_wdat got %h want cafef00d", wb_wdat); end
    nvec++; if (wb_wsel !== 5'd9) begin nfail++; $display("FAIL miss_wsel got %0d want 9", wb_wsel); end
    clear_inputs();
  endtask

  task automatic test_store_miss();
    clear_inputs();
    ex_dmemWEN = 1; ex_rdat2 = 32'h12345678; ex_aluResult = 32'h80; ex_regwrite = 0;
    for (int i = 0; i < 3; i++) begin
      dhit = (i == 2);
      #1;
      nvec++; if (dmemWEN !== 1'b1) begin nfail++; $display("FAIL st_wen[%0d] got %b want 1", i, dmemWEN); end
      nvec++; if (dmemstore !== 32'h12345678) begin nfail++; $display("FAIL st_data[%0d] got %h want 12345678", i, dmemstore); end
      nvec++; if (stall !== (i < 2)) begin nfail++; $display("FAIL st_stall[%0d] got %b want %b", i, stall, (i < 2)); end
      tick();
      nvec++; if (wb_regwrite !== 1'b0) begin nfail++; $display("FAIL st_wb_regwrite[%0d] got %b want 0", i, wb_regwrite); end
    end
    clear_inputs();
  endtask

  task automatic test_passthrough();
    logic [1:0]  mtr [3]  = '{2'b00, 2'b10, 2'b11};
    logic [31:0] exp [3]  = '{32'd7, 32'h104, 32'hABCD0000};
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      ex_aluResult = 7; ex_npc = 32'h104; ex_upper16 = 32'hABCD0000;
      ex_memtoreg = mtr[i]; ex_regwrite = 1; ex_wsel = 5'(i + 1);
      dhit = (i == 1);  // stray hit without a request must be ignored
      dmemload = 32'hFFFF_FFFF;
      #1;
      nvec++; if (stall !== 1'b0) begin nfail++; $display("FAIL pt_stall[%0d] got %b want 0", i, stall); end
      nvec++; if ({dmemREN, dmemWEN} !== 2'b00) begin nfail++; $display("FAIL pt_req[%0d] got %b want 00", i, {dmemREN, dmemWEN}); end
      tick();
      nvec++; if (wb_wdat !== exp[i]) begin nfail++; $display("FAIL pt_wdat[%0d] got %h want %h", i, wb_wdat, exp[i]); end
      nvec++; if (wb_wsel !== 5'(i + 1)) begin nfail++; $display("FAIL pt_wsel[%0d] got %0d want %0d", i, wb_wsel, i + 1); end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    ex_dmemREN = 1; dhit = 1; dmemload = 32'h0BAD_F00D; ex_memtoreg = 2'b01;
    ex_wsel = 12; ex_regwrite = 1;
    tick();
    nvec++; if (wb_wdat !== 32'h0BAD_F00D) begin nfail++; $display("FAIL b2b_wdat0 got %h want 0badf00d", wb_wdat); end
    clear_inputs();
    ex_aluResult = 32'h55; ex_memtoreg = 2'b00; ex_wsel = 13; ex_regwrite = 1;
    tick();
    nvec++; if (wb_wdat !== 32'h55) begin nfail++; $display("FAIL b2b_wdat1 got %h want 00000055", wb_wdat); end
    nvec++; if (wb_wsel !== 5'd13) begin nfail++; $display("FAIL b2b_wsel1 got %0d want 13", wb_wsel); end
    clear_inputs();
    tick();
    nvec++; if (wb_regwrite !== 1'b0) begin nfail++; $display("FAIL b2b_idle_regwrite got %b want 0", wb_regwrite); end
  endtask

  task automatic test_halt();
    clear_inputs();
    ex_halt = 1; ex_regwrite = 1; ex_wsel = 4; ex_aluResult = 32'h11;
    #1;
    nvec++; if (stall !== 1'b0) begin nfail++; $display("FAIL halt_entry_stall got %b want 0", stall); end
    tick();
    nvec++; if (wb_halt !== 1'b1) begin nfail++; $display("FAIL halt_wb_halt got %b want 1", wb_halt); end
    nvec++; if (wb_regwrite !== 1'b1) begin nfail++; $display("FAIL halt_wb_regwrite got %b want 1", wb_regwrite); end
    clear_inputs();
    ex_dmemREN = 1; ex_regwrite = 1; ex_wsel = 6; dhit = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      nvec++; if (dmemREN !== 1'b0) begin nfail++; $display("FAIL halted_ren[%0d] got %b want 0", i, dmemREN); end
      nvec++; if (stall !== 1'b1) begin nfail++; $display("FAIL halted_stall[%0d] got %b want 1", i, stall); end
      tick();
      nvec++; if (wb_halt !== 1'b1) begin nfail++; $display("FAIL halted_wb_halt[%0d] got %b want 1", i, wb_halt); end
      nvec++; if (wb_regwrite !== 1'b0) begin nfail++; $display("FAIL halted_regwrite[%0d] got %b want 0", i, wb_regwrite); end
    end
    nRST = 0;
    #1;
    nvec++; if (wb_halt !== 1'b0) begin nfail++; $display("FAIL halt_reset_wb_halt got %b want 0", wb_halt); end
    nvec++; if (dmemREN !== 1'b1) begin nfail++; $display("FAIL halt_reset_ren got %b want 1", dmemREN); end
    tick();
    nRST = 1;
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_in_wait();
    clear_inputs();
    ex_dmemREN = 1; ex_memtoreg = 2'b01; ex_wsel = 3; ex_regwrite = 1;
    dmemload = 32'h1111_2222;
    tick();
    #1;
    nvec++; if (stall !== 1'b1) begin nfail++; $display("FAIL rw_wait_stall got %b want 1", stall); end
    #2;
    nRST = 0;
    dhit = 1;
    #1;
    nvec++; if ({wb_regwrite, wb_wsel, wb_wdat, wb_halt} !== 39'd0) begin nfail++; $display("FAIL rw_wb_zero got %b/%0d/%h/%b want 0", wb_regwrite, wb_wsel, wb_wdat, wb_halt); end
    tick();
    nvec++; if (wb_regwrite !== 1'b0) begin nfail++; $display("FAIL rw_held_regwrite got %b want 0", wb_regwrite); end
    nRST = 1;
    clear_inputs();
    ex_dmemREN = 1; dhit = 1; dmemload = 32'h55AA55AA; ex_memtoreg = 2'b01;
    ex_wsel = 7; ex_regwrite = 1;
    #1;
    nvec++; if (stall !== 1'b0) begin nfail++; $display("FAIL rw_after_stall got %b want 0", stall); end
    tick();
    nvec++; if (wb_wdat !== 32'h55AA55AA) begin nfail++; $display("FAIL rw_after_wdat got %h want 55aa55aa", wb_wdat); end
    nvec++; if (wb_wsel !== 5'd7) begin nfail++; $display("FAIL rw_after_wsel got %0d want 7", wb_wsel); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_load_miss();
    test_store_miss();
    test_passthrough();
    test_back_to_back();
    test_halt();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 CLK  in  1  clock; all state rising-edge.
REQ-002 nRST  in  1  reset, asynchronous, active-low.
REQ-003 ex_memtoreg  in  2  WB source select from EX/MEM: 00 ALU, 01 load data, 10 npc, 11 upper16.
REQ-004 ex_regwrite / ex_dmemREN / ex_dmemWEN / ex_halt  in  1 each  EX/MEM control bits.
REQ-005 ex_aluResult / ex_rdat2 / ex_npc / ex_upper16  in  32 each  address or ALU value, store data, PC+4, LUI value.
REQ-006 ex_wsel  in  5  destination register.
REQ-007 dhit  in  1  data cache hit/ack; dmemload  in  32  load data, valid when dhit=1.
REQ-008 dmemREN / dmemWEN  out  1  cache request; dmemaddr  out  32 (=ex_aluResult); dmemstore  out  32 (=ex_rdat2).
REQ-009 stall  out  1  combinational; 1 freezes PC, IF/ID, ID/EX, EX/MEM.
REQ-010 wb_regwrite  out  1; wb_wsel  out  5; wb_wdat  out  32; wb_halt  out  1  registered MEM/WB outputs.

Function
REQ-011 FSM states IDLE, WAIT, HALTED; encoding a shared enum.
REQ-012 Request (req) = ex_dmemREN | ex_dmemWEN; REN and WEN both 1 is illegal, and the block SHALL treat it as a read plus a write, with no check.
REQ-013 IDLE: dmemREN/WEN = ex_dmemREN/WEN combinationally in the same cycle.
REQ-014 IDLE with req and dhit=1: access completes this cycle, stall=0, next state IDLE.
REQ-015 IDLE with req and dhit=0: stall=1, next state WAIT.
REQ-016 WAIT: request held, stall = !dhit; on dhit=1 complete, next IDLE; no timeout.
REQ-017 No req: stall=0, zero-latency pass-through, no cache request.
REQ-018 Complete cycle (stall=0): MEM/WB register loads wb_regwrite=ex_regwrite, wb_wsel=ex_wsel, wb_halt=ex_halt, wb_wdat=mux(ex_memtoreg) using dmemload for 01.
REQ-019 Stall cycle: MEM/WB loads bubble (wb_regwrite=0, wb_halt=0, wb_wsel=0, wb_wdat=0) so no duplicate register write.
REQ-020 Latency: exactly 1 cycle from completion to WB outputs; 1 + miss cycles for a missing access.
REQ-021 ex_halt=1 in a complete cycle: wb_halt=1 next edge, next state HALTED.
REQ-022 HALTED: dmemREN=dmemWEN=0, stall=1, wb_regwrite=0, wb_halt held 1 until reset; all inputs ignored.
REQ-023 ex_halt with req: memory access completes first, halt takes effect on the completing cycle.
REQ-024 dhit=1 without req: ignored.

Reset
REQ-025 nRST=0 asynchronously: state IDLE; wb_regwrite=0, wb_wsel=0, wb_wdat=0, wb_halt=0.
REQ-026 Reset mid-WAIT: request dropped the same instant (combinational outputs follow IDLE with current inputs); no partial write-back.
REQ-027 Reset while HALTED: return to IDLE, wb_halt=0.

Structure
REQ-028 The shared cpu types package SHALL hold the memtoreg encoding enum (MTR_ALU, MTR_LOAD, MTR_NPC, MTR_LUI), the FSM state enum, and the word_t/regbits_t typedefs.
REQ-029 The MEM/WB register SHALL be a sub-module mem_wb_latch with a load/bubble select; FSM and mux stay in mem_wb_stage.

Verification
REQ-030 Load hit: req REN, addr 0x40, dhit=1, dmemload=0xDEADBEEF, memtoreg=01, wsel=5, regwrite=1 -> stall 0; next edge wb_wdat=0xDEADBEEF, wb_wsel=5, wb_regwrite=1.
REQ-031 Load miss 3 cycles: dhit=0,0,0,1 -> stall 1,1,1,0; dmemREN held 4 cycles; WB shows 3 bubbles (wb_regwrite=0), then one write.
REQ-032 Store miss: WEN, dmemstore=0x12345678, regwrite=0, dhit after 2 cycles -> dmemWEN/dmemstore stable throughout, stall 1,1,0, wb_regwrite=0 always.
REQ-033 ALU/npc/LUI pass-through: memtoreg 00/10/11 with aluResult=7, npc=0x104, upper16=0xABCD0000 -> wb_wdat 7, 0x104, 0xABCD0000 one cycle later, stall 0.
REQ-034 Halt: ex_halt=1 with no req -> wb_halt=1 next edge and held; later ex_dmemREN=1 produces no request; stall=1.
REQ-035 Reset in WAIT: assert nRST mid-miss -> WB outputs 0 immediately; after release, new hit completes normally.
